// File: rtl/nios2_ocimem_debug_arbiter_if.sv
// nios2_ocimem_debug_arbiter_if: JTAG, Avalon debug-slave and OCI RAM signals of the debug RAM arbiter
interface nios2_ocimem_debug_arbiter_if #(parameter int ADDR_W = 8);
  logic [37:0] jdo;
  logic take_action_ocimem_a;
  logic take_action_ocimem_b;
  logic take_no_action_ocimem_a;
  logic [ADDR_W-1:0] avs_address;
  logic avs_read;
  logic avs_write;
  logic [31:0] avs_writedata;
  logic [3:0] avs_byteenable;
  logic avs_waitrequest;
  logic [31:0] avs_readdata;
  logic avs_readdatavalid;
  logic [ADDR_W-1:0] ram_addr;
  logic ram_wren;
  logic [3:0] ram_byteen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic monitor_ready;
  logic jtag_overflow;
  modport master (
    output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, ram_rdata,
    input avs_waitrequest, avs_readdata, avs_readdatavalid,
    input ram_addr, ram_wren, ram_byteen, ram_wdata, MonDReg, monitor_ready, jtag_overflow
  );
  modport slave (
    input jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    input avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, ram_rdata,
    output avs_waitrequest, avs_readdata, avs_readdatavalid,
    output ram_addr, ram_wren, ram_byteen, ram_wdata, MonDReg, monitor_ready, jtag_overflow
  );
endinterface

// File: rtl/nios2_ocimem_debug_arbiter.sv
// nios2_ocimem_debug_arbiter: arbitrates the OCI debug RAM between the JTAG path and the CPU debug slave
module nios2_ocimem_debug_arbiter #(
  parameter int ADDR_W = 8,
  parameter int MAX_WAIT = 4
) (
  input logic clk,
  input logic reset,
  nios2_ocimem_debug_arbiter_if.slave bus
);
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d, pend_addr_q, pend_addr_d;
  logic [31:0] pend_data_q, pend_data_d, rdata_q, mon_q;
  logic [3:0] wait_q, wait_d;
  logic [1:0] out_q, out_d;
  logic pend_q, pend_d, pend_wr_q, pend_wr_d, ovf_q, ovf_d, rdy_q, rdy_d;
  logic rd_cpu_q, rd_cpu_d, rd_jtag_q, rd_jtag_d, rdv_q;
  logic cpu_req, ld, jw, jr, jnew, force_cpu, g_cpu, g_pend, g_new, drop, accept, store, complete;
  logic unused_jdo;
  assign unused_jdo = ^{bus.jdo[37:35], bus.jdo[2:0]};
  always_comb begin
    cpu_req = ~reset & (bus.avs_read | bus.avs_write);
    ld = ~reset & bus.take_action_ocimem_a;
    jw = ~reset & ~bus.take_action_ocimem_a & bus.take_action_ocimem_b;
    jr = ~reset & ~bus.take_action_ocimem_a & ~bus.take_action_ocimem_b & bus.take_no_action_ocimem_a;
    jnew = jw | jr;
    force_cpu = cpu_req && wait_q == MW;
    g_pend = ~force_cpu & pend_q;
    g_new = ~force_cpu & ~pend_q & jnew;
    g_cpu = cpu_req & ~g_pend & ~g_new;
    drop = jnew & pend_q & ~g_pend;
    accept = jnew & ~drop;
    store = accept & ~g_new;
    rd_cpu_d = g_cpu & bus.avs_read;
    rd_jtag_d = (g_pend & ~pend_wr_q) | (g_new & jr);
    complete = (g_pend & pend_wr_q) | (g_new & jw) | rd_jtag_q;
    jtag_addr_d = ld ? bus.jdo[16+ADDR_W:17] : accept ? jtag_addr_q + ADDR_W'(1) : jtag_addr_q;
    pend_d = store | (pend_q & ~g_pend);
    pend_addr_d = store ? jtag_addr_q : pend_addr_q;
    pend_wr_d = store ? jw : pend_wr_q;
    pend_data_d = store ? bus.jdo[34:3] : pend_data_q;
    wait_d = (~cpu_req | g_cpu) ? 4'd0 : wait_q + 4'd1;
    ovf_d = ld ? 1'b0 : ovf_q | drop;
    out_d = out_q + {1'b0, accept} - {1'b0, complete};
    rdy_d = (accept | complete) ? out_d == 2'd0 : rdy_q;
    bus.ram_addr = g_cpu ? bus.avs_address : g_pend ? pend_addr_q : g_new ? jtag_addr_q : '0;
    bus.ram_wren = g_cpu ? bus.avs_write : g_pend ? pend_wr_q : g_new & jw;
    bus.ram_byteen = g_cpu ? bus.avs_byteenable : (g_pend | g_new) ? 4'hF : 4'h0;
    bus.ram_wdata = g_cpu ? bus.avs_writedata : g_pend ? pend_data_q : g_new ? bus.jdo[34:3] : '0;
    bus.avs_waitrequest = cpu_req & ~g_cpu;
    bus.avs_readdata = rdata_q;
    bus.avs_readdatavalid = rdv_q;
    bus.MonDReg = mon_q;
    bus.monitor_ready = rdy_q;
    bus.jtag_overflow = ovf_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      jtag_addr_q <= '0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      pend_q <= 1'b0;
      pend_wr_q <= 1'b0;
      wait_q <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
      rdy_q <= 1'b0;
      rd_cpu_q <= 1'b0;
      rd_jtag_q <= 1'b0;
      rdv_q <= 1'b0;
      rdata_q <= '0;
      mon_q <= '0;
    end else begin
      jtag_addr_q <= jtag_addr_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      pend_q <= pend_d;
      pend_wr_q <= pend_wr_d;
      wait_q <= wait_d;
      out_q <= out_d;
      ovf_q <= ovf_d;
      rdy_q <= rdy_d;
      rd_cpu_q <= rd_cpu_d;
      rd_jtag_q <= rd_jtag_d;
      rdv_q <= rd_cpu_q;
      rdata_q <= rd_cpu_q ? bus.ram_rdata : rdata_q;
      mon_q <= rd_jtag_q ? bus.ram_rdata : mon_q;
    end
  end
endmodule
